reg_file_shadow: RTL and testbench
==================================

Name: reg_file_shadow

Overview:
- Register file and shadow stack that execute the register-side controls from the multicycle control unit: RegR1, RegR2, RegW1, RegW2, backup and restore.
- Holds NREGS general registers, including a dedicated compare register (CR) written by RegW1.
- backup (on a call) pushes a full snapshot of the register file onto an internal stack in one cycle.
- restore (on a return) pops the top snapshot back into the register file in one cycle.

Parameters:
DW, 16, register width in bits
NREGS, 16, number of registers
AW, 4, register address width (2^AW >= NREGS)
CR_IDX, 1, index of the compare register written by RegW1
DEPTH, 4, shadow stack depth (number of snapshots)
R0_ZERO, 1, 1 = register 0 reads as 0 and ignores writes

Ports:
clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
RegR1  in  1  capture read port 1
RegR2  in  1  capture read port 2
RegW1  in  1  write wdata1 to register CR_IDX
RegW2  in  1  write wdata2 to register waddr2
backup  in  1  push snapshot of all registers
restore  in  1  pop snapshot into registers
raddr1  in  AW  read address 1
raddr2  in  AW  read address 2
waddr2  in  AW  write address for RegW2
wdata1  in  DW  CR write data
wdata2  in  DW  general write data
rdata1  out  DW  registered read data 1
rdata2  out  DW  registered read data 2
cr_out  out  DW  current CR contents (straight from flops)
depth  out  clog2(DEPTH+1)  snapshots held
full  out  1  depth == DEPTH
empty  out  1  depth == 0
overflow  out  1  sticky: backup while full
underflow  out  1  sticky: restore while empty
proto_err  out  1  sticky: backup and restore in same cycle

Behaviour:
- Reset (synchronous, wins over all inputs), one edge completes it:
  - all registers, rdata1, rdata2 and stack contents = 0
  - depth = 0, so empty = 1 and full = 0
  - overflow, underflow, proto_err = 0
- Reset may arrive mid-operation, e.g. during a pending push; the result is exactly as above with no partial update.
- Reads:
  - RegR1 high: rdata1 <= reg[raddr1] as it stood before the edge; RegR2 likewise into rdata2.
  - One-cycle latency. No write-to-read bypass: a same-cycle write to the same address returns the old value.
  - When RegRx is low, rdatax holds its value.
  - raddr >= NREGS reads 0.
- Writes:
  - RegW2: reg[waddr2] <= wdata2.
  - RegW1: reg[CR_IDX] <= wdata1.
  - If both target CR_IDX in the same cycle, RegW1 wins.
  - Writes to address >= NREGS are ignored.
  - With R0_ZERO=1, writes to reg 0 are ignored and reg 0 always reads 0.
- backup (restore low):
  - If not full: stack[depth] <= pre-edge snapshot of all registers, and depth + 1.
  - Same-cycle RegW1/RegW2 still update the live file; the snapshot holds the pre-write values.
  - If full: no push, depth unchanged, overflow <= 1, same-cycle writes still apply.
- restore (backup low):
  - If not empty: all registers <= stack[depth-1], and depth - 1.
  - Restore overrides same-cycle RegW1/RegW2 (those writes are dropped).
  - Same-cycle reads return the pre-restore values.
  - If empty: registers unchanged, underflow <= 1, same-cycle writes still apply.
- backup and restore both high:
  - Stack and depth unchanged, proto_err <= 1.
  - Writes and reads proceed normally.
- Stack ordering:
  - LIFO; a slot is not cleared on pop.
  - Nested push/pop sequences up to DEPTH are exact.
  - A push after a pop overwrites the vacated slot.
- Sticky flags clear only on Reset.
- Combinational outputs: full, empty and cr_out derive from flops only; there is no input-to-output path.

Test Plan:
1. Reset, then RegW2 waddr2=3 wdata2=0xBEEF. Next cycle RegR1 raddr1=3 -> rdata1=0xBEEF one cycle later. raddr1=0 after a write of 0x1234 to reg 0 -> rdata1=0x0000.
2. Same-cycle RegW1 wdata1=0x0001 and RegW2 waddr2=1 wdata2=0x00FF -> cr_out=0x0001. Read of reg 1 in that same cycle returns the old value 0x0000.
3. Write reg 2=0x0AAA, backup with a same-cycle write reg 2=0x0BBB -> depth=1 and reg 2=0x0BBB. Then restore -> reg 2=0x0AAA, depth=0, empty=1.
4. Four backups with reg 5 = 1,2,3,4 -> full=1. A fifth backup -> overflow=1, depth=4. Four restores -> reg 5 = 4,3,2,1 in sequence.
5. Restore while empty with a same-cycle RegW2 reg 4=0x0042 -> underflow=1, reg 4=0x0042, depth=0.
6. backup and restore together at depth=2 -> proto_err=1, depth=2. Then Reset asserted mid-sequence -> depth=0, all flags 0, rdata1=rdata2=0.

Source files
------------

// File: rtl/reg_file_shadow.sv
// Register file with a LIFO shadow stack of full-file snapshots.
// Ports: clk/Reset, RegR1/RegR2 reads, RegW1 (CR) and RegW2 writes,
// backup/restore stack ops, depth/full/empty status, sticky error flags.
module reg_file_shadow #(
  parameter int DW      = 16,
  parameter int NREGS   = 16,
  parameter int AW      = 4,
  parameter int CR_IDX  = 1,
  parameter int DEPTH   = 4,
  parameter int R0_ZERO = 1,
  localparam int DPW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           RegR1,
  input  logic           RegR2,
  input  logic           RegW1,
  input  logic           RegW2,
  input  logic           backup,
  input  logic           restore,
  input  logic [AW-1:0]  raddr1,
  input  logic [AW-1:0]  raddr2,
  input  logic [AW-1:0]  waddr2,
  input  logic [DW-1:0]  wdata1,
  input  logic [DW-1:0]  wdata2,
  output logic [DW-1:0]  rdata1,
  output logic [DW-1:0]  rdata2,
  output logic [DW-1:0]  cr_out,
  output logic [DPW-1:0] depth,
  output logic           full,
  output logic           empty,
  output logic           overflow,
  output logic           underflow,
  output logic           proto_err
);

  logic [DW-1:0] regs  [NREGS];
  logic [DW-1:0] stack [DEPTH][NREGS];
  // Full address space view; slots past NREGS read as zero.
  logic [DW-1:0] rview [2**AW];
  logic          push;
  logic          pop;

  assign full   = (depth == DPW'(DEPTH));
  assign empty  = (depth == '0);
  assign cr_out = regs[CR_IDX];
  assign push   = backup && !restore && !full;
  assign pop    = restore && !backup && !empty;

  always_comb begin
    for (int i = 0; i < 2**AW; i++)
      rview[i] = '0;
    for (int i = 0; i < NREGS; i++)
      rview[i] = regs[i];
    if (R0_ZERO != 0)
      rview[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      for (int s = 0; s < DEPTH; s++)
        for (int i = 0; i < NREGS; i++)
          stack[s][i] <= '0;
      rdata1    <= '0;
      rdata2    <= '0;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (RegR1)
        rdata1 <= rview[raddr1];
      if (RegR2)
        rdata2 <= rview[raddr2];

      // A pop replaces the whole file, so it drops same-cycle writes.
      for (int i = 0; i < NREGS; i++) begin
        if (pop) begin
          for (int s = 0; s < DEPTH; s++)
            if (depth == DPW'(s + 1))
              regs[i] <= stack[s][i];
        end else begin
          if (RegW2 && waddr2 == AW'(i))
            regs[i] <= wdata2;
          // Later assignment: the CR port wins a same-target collision.
          if (RegW1 && i == CR_IDX)
            regs[i] <= wdata1;
        end
        if (R0_ZERO != 0 && i == 0)
          regs[i] <= '0;
      end

      // Snapshot takes the pre-edge (pre-write) register values.
      for (int s = 0; s < DEPTH; s++)
        if (push && depth == DPW'(s))
          for (int i = 0; i < NREGS; i++)
            stack[s][i] <= regs[i];

      unique case (1'b1)
        push:    depth <= depth + 1'b1;
        pop:     depth <= depth - 1'b1;
        default: ;
      endcase

      overflow  <= overflow  | (backup && !restore && full);
      underflow <= underflow | (restore && !backup && empty);
      proto_err <= proto_err | (backup && restore);
    end
  end

endmodule

// File: tb/tb_reg_file_shadow.sv
// Self-checking bench for reg_file_shadow.
// Expected read data is queued at issue and popped one cycle later.
module tb_reg_file_shadow;

  logic        clk = 1'b0;
  logic        Reset;
  logic        RegR1, RegR2, RegW1, RegW2;
  logic        backup, restore;
  logic [3:0]  raddr1, raddr2, waddr2;
  logic [15:0] wdata1, wdata2;
  logic [15:0] rdata1, rdata2, cr_out;
  logic [2:0]  depth;
  logic        full, empty, overflow, underflow, proto_err;

  int vecs = 0;
  int miss = 0;
  logic [15:0] sb1 [$];
  logic [15:0] sb2 [$];
  logic [15:0] e;

  always #5 clk = ~clk;

  reg_file_shadow dut (
    .clk(clk), .Reset(Reset),
    .RegR1(RegR1), .RegR2(RegR2),
    .RegW1(RegW1), .RegW2(RegW2),
    .backup(backup), .restore(restore),
    .raddr1(raddr1), .raddr2(raddr2),
    .waddr2(waddr2),
    .wdata1(wdata1), .wdata2(wdata2),
    .rdata1(rdata1), .rdata2(rdata2),
    .cr_out(cr_out), .depth(depth),
    .full(full), .empty(empty),
    .overflow(overflow),
    .underflow(underflow),
    .proto_err(proto_err)
  );

  task automatic idle();
    Reset = 0; RegR1 = 0; RegR2 = 0;
    RegW1 = 0; RegW2 = 0;
    backup = 0; restore = 0;
    raddr1 = 0; raddr2 = 0; waddr2 = 0;
    wdata1 = 0; wdata2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr2(input logic [3:0] a,
                     input logic [15:0] d);
    RegW2 = 1; waddr2 = a; wdata2 = d;
    tick();
  endtask

  task automatic test_reset();
    idle();
    Reset = 1;
    RegW2 = 1; waddr2 = 4'd3; wdata2 = 16'h5555;
    backup = 1;
    tick();
    vecs++;
    if ({rdata1, rdata2} !== 32'h0) begin
      miss++;
      $display("FAIL reset_rdata got %h/%h exp 0000/0000",
               rdata1, rdata2);
    end
    vecs++;
    if ({depth, full, empty} !== 5'b00001) begin
      miss++;
      $display("FAIL reset_status got d=%0d f=%b e=%b exp d=0 f=0 e=1",
               depth, full, empty);
    end
    vecs++;
    if ({overflow, underflow, proto_err} !== 3'b000) begin
      miss++;
      $display("FAIL reset_flags got %b%b%b exp 000",
               overflow, underflow, proto_err);
    end
    vecs++;
    if (cr_out !== 16'h0) begin
      miss++;
      $display("FAIL reset_cr got %h exp 0000", cr_out);
    end
  endtask

  task automatic test_write_read();
    wr2(4'd3, 16'hBEEF);
    RegR1 = 1; raddr1 = 4'd3; sb1.push_back(16'hBEEF);
    RegR2 = 1; raddr2 = 4'd3; sb2.push_back(16'hBEEF);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL wr_rd1 got %h exp %h", rdata1, e);
    end
    e = sb2.pop_front(); vecs++;
    if (rdata2 !== e) begin
      miss++;
      $display("FAIL wr_rd2 got %h exp %h", rdata2, e);
    end
    wr2(4'd0, 16'h1234);
    RegR1 = 1; raddr1 = 4'd0; sb1.push_back(16'h0000);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL r0_zero got %h exp %h", rdata1, e);
    end
    RegR2 = 1; raddr2 = 4'd9; sb2.push_back(16'h0000);
    tick();
    tick();
    e = sb2.pop_front(); vecs++;
    if (rdata2 !== e) begin
      miss++;
      $display("FAIL rd2_hold got %h exp %h", rdata2, e);
    end
  endtask

  task automatic test_dual_write();
    RegW1 = 1; wdata1 = 16'h0001;
    RegW2 = 1; waddr2 = 4'd1; wdata2 = 16'h00FF;
    RegR1 = 1; raddr1 = 4'd1; sb1.push_back(16'h0000);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL no_bypass got %h exp %h", rdata1, e);
    end
    vecs++;
    if (cr_out !== 16'h0001) begin
      miss++;
      $display("FAIL cr_w1_wins got %h exp 0001", cr_out);
    end
    RegR1 = 1; raddr1 = 4'd1; sb1.push_back(16'h0001);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL cr_read got %h exp %h", rdata1, e);
    end
  endtask

  task automatic test_backup_restore();
    wr2(4'd2, 16'h0AAA);
    backup = 1;
    RegW2 = 1; waddr2 = 4'd2; wdata2 = 16'h0BBB;
    tick();
    vecs++;
    if (depth !== 3'd1) begin
      miss++;
      $display("FAIL push_depth got %0d exp 1", depth);
    end
    RegR1 = 1; raddr1 = 4'd2; sb1.push_back(16'h0BBB);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL push_live got %h exp %h", rdata1, e);
    end
    restore = 1;
    RegW2 = 1; waddr2 = 4'd6; wdata2 = 16'h6666;
    RegR2 = 1; raddr2 = 4'd2; sb2.push_back(16'h0BBB);
    tick();
    e = sb2.pop_front(); vecs++;
    if (rdata2 !== e) begin
      miss++;
      $display("FAIL pop_rd_old got %h exp %h", rdata2, e);
    end
    vecs++;
    if ({depth, empty} !== 4'b0001) begin
      miss++;
      $display("FAIL pop_depth got d=%0d e=%b exp d=0 e=1",
               depth, empty);
    end
    RegR1 = 1; raddr1 = 4'd2; sb1.push_back(16'h0AAA);
    RegR2 = 1; raddr2 = 4'd6; sb2.push_back(16'h0000);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL pop_reg2 got %h exp %h", rdata1, e);
    end
    e = sb2.pop_front(); vecs++;
    if (rdata2 !== e) begin
      miss++;
      $display("FAIL pop_drops_wr got %h exp %h", rdata2, e);
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 4; k++) begin
      wr2(4'd5, 16'(k));
      backup = 1;
      tick();
    end
    vecs++;
    if ({full, depth} !== 4'b1100) begin
      miss++;
      $display("FAIL full got f=%b d=%0d exp f=1 d=4", full, depth);
    end
    backup = 1;
    RegW2 = 1; waddr2 = 4'd7; wdata2 = 16'h0077;
    tick();
    vecs++;
    if ({overflow, depth} !== 4'b1100) begin
      miss++;
      $display("FAIL overflow got o=%b d=%0d exp o=1 d=4",
               overflow, depth);
    end
    RegR1 = 1; raddr1 = 4'd7; sb1.push_back(16'h0077);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL ovf_write got %h exp %h", rdata1, e);
    end
    for (int k = 4; k >= 1; k--) begin
      restore = 1;
      tick();
      RegR1 = 1; raddr1 = 4'd5; sb1.push_back(16'(k));
      tick();
      e = sb1.pop_front(); vecs++;
      if (rdata1 !== e) begin
        miss++;
        $display("FAIL lifo_%0d got %h exp %h", k, rdata1, e);
      end
    end
    vecs++;
    if ({empty, depth} !== 4'b1000) begin
      miss++;
      $display("FAIL lifo_empty got e=%b d=%0d exp e=1 d=0",
               empty, depth);
    end
  endtask

  task automatic test_underflow();
    restore = 1;
    RegW2 = 1; waddr2 = 4'd4; wdata2 = 16'h0042;
    tick();
    vecs++;
    if ({underflow, depth} !== 4'b1000) begin
      miss++;
      $display("FAIL underflow got u=%b d=%0d exp u=1 d=0",
               underflow, depth);
    end
    RegR1 = 1; raddr1 = 4'd4; sb1.push_back(16'h0042);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL unf_write got %h exp %h", rdata1, e);
    end
  endtask

  task automatic test_proto_reset();
    backup = 1; tick();
    backup = 1; tick();
    backup = 1; restore = 1;
    RegR1 = 1; raddr1 = 4'd4; sb1.push_back(16'h0042);
    RegR2 = 1; raddr2 = 4'd3; sb2.push_back(16'hBEEF);
    tick();
    vecs++;
    if ({proto_err, depth} !== 4'b1010) begin
      miss++;
      $display("FAIL proto got p=%b d=%0d exp p=1 d=2",
               proto_err, depth);
    end
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL proto_rd1 got %h exp %h", rdata1, e);
    end
    e = sb2.pop_front(); vecs++;
    if (rdata2 !== e) begin
      miss++;
      $display("FAIL proto_rd2 got %h exp %h", rdata2, e);
    end
    Reset = 1; backup = 1;
    RegW1 = 1; wdata1 = 16'h7777;
    tick();
    vecs++;
    if ({depth, empty, overflow, underflow, proto_err}
        !== 7'b0001000) begin
      miss++;
      $display("FAIL mid_reset got d=%0d e=%b o=%b u=%b p=%b exp 0 1 0 0 0",
               depth, empty, overflow, underflow, proto_err);
    end
    vecs++;
    if ({rdata1, rdata2, cr_out} !== 48'h0) begin
      miss++;
      $display("FAIL mid_reset_data got %h/%h/%h exp 0/0/0",
               rdata1, rdata2, cr_out);
    end
    RegR1 = 1; raddr1 = 4'd4; sb1.push_back(16'h0000);
    tick();
    e = sb1.pop_front(); vecs++;
    if (rdata1 !== e) begin
      miss++;
      $display("FAIL reset_regs got %h exp %h", rdata1, e);
    end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_write_read();
    test_dual_write();
    test_backup_restore();
    test_overflow();
    test_underflow();
    test_proto_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
